// File: rtl/multdiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multdiv_iter: iterative signed multiply (shift-add or radix-4 Booth when  |
// | MULTDIV_BOOTH_EN is defined) and restoring divide.          Rev 1.0       |
// +--------------------------------------------------------------------------+
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
`ifdef MULTDIV_BOOTH_EN
  localparam int MUL_STEPS = WIDTH / 2;
  localparam int MQ_W      = WIDTH + 1;
`else
  localparam int MUL_STEPS = WIDTH;
  localparam int MQ_W      = WIDTH;
`endif
  localparam logic [CW-1:0]    MUL_LAST = CW'(MUL_STEPS - 1);
  localparam logic [CW-1:0]    DIV_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [MQ_W-1:0]    mq;
  logic [WIDTH-1:0]   rem, quo, dvsr;
  logic               neg_q, div_zero, div_ovf;

  logic [2*WIDTH-1:0] mul_addend, acc_next, mcand_next;
  logic [MQ_W-1:0]    mq_next;
  logic [WIDTH:0]     mul_top;
  logic               mul_ovf;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next, quo_next, quo_signed;

  always_comb begin
    mul_addend = '0;
`ifdef MULTDIV_BOOTH_EN
    // mq[2:0] is the current Booth triple {b(2i+1), b(2i), b(2i-1)}
    case (mq[2:0])
      3'b001, 3'b010: mul_addend = mcand;
      3'b011:         mul_addend = mcand << 1;
      3'b100:         mul_addend = -(mcand << 1);
      3'b101, 3'b110: mul_addend = -mcand;
      default:        mul_addend = '0;
    endcase
    mq_next    = {{2{mq[MQ_W-1]}}, mq[MQ_W-1:2]};
    mcand_next = mcand << 2;
`else
    // The multiplier's sign bit carries negative weight in the final step
    if (mq[0]) mul_addend = (count == MUL_LAST) ? -mcand : mcand;
    mq_next    = {mq[MQ_W-1], mq[MQ_W-1:1]};
    mcand_next = mcand << 1;
`endif
    acc_next = acc + mul_addend;
    mul_top  = acc_next[2*WIDTH-1:WIDTH-1];
    mul_ovf  = !((&mul_top) || !(|mul_top));

    div_shift  = {rem, quo[WIDTH-1]};
    div_diff   = div_shift - {1'b0, dvsr};
    div_ge     = !div_diff[WIDTH];
    rem_next   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next   = {quo[WIDTH-2:0], div_ge};
    quo_signed = neg_q ? -quo_next : quo_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      mcand          <= '0;
      acc            <= '0;
      mq             <= '0;
      rem            <= '0;
      quo            <= '0;
      dvsr           <= '0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= MUL;
        busy  <= 1'b1;
        count <= '0;
        acc   <= '0;
        mcand <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
`ifdef MULTDIV_BOOTH_EN
        mq    <= {data_operandB, 1'b0};
`else
        mq    <= data_operandB;
`endif
      end else if (ctrl_DIV) begin
        state    <= DIV;
        busy     <= 1'b1;
        count    <= '0;
        rem      <= '0;
        quo      <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        dvsr     <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == MIN_VAL) && (data_operandB == '1);
      end else begin
        case (state)
          MUL: begin
            acc   <= acc_next;
            mq    <= mq_next;
            mcand <= mcand_next;
            count <= count + 1'b1;
            if (count == MUL_LAST) begin
              state          <= DONE;
              busy           <= 1'b0;
              count          <= '0;
              data_resultRDY <= 1'b1;
              data_result    <= acc_next[WIDTH-1:0];
              data_exception <= mul_ovf;
            end
          end
          DIV: begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == DIV_LAST) begin
              state          <= DONE;
              busy           <= 1'b0;
              count          <= '0;
              data_resultRDY <= 1'b1;
              data_result    <= div_zero ? '0 : quo_signed;
              data_exception <= div_zero || div_ovf;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multdiv_iter: directed and randomized checks of multdiv_iter against   |
// | an arithmetic reference model.                              Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_multdiv_iter;
  localparam int W = 32;
`ifdef MULTDIV_BOOTH_EN
  localparam int MLAT = W / 2 + 1;
`else
  localparam int MLAT = W + 1;
`endif
  localparam int DLAT = W + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ctrl_MULT = 1'b0;
  logic          ctrl_DIV = 1'b0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic [W-1:0]  data_result;
  logic          data_exception;
  logic          data_resultRDY;
  logic          busy;

  int tests = 0;
  int failed = 0;

  multdiv_iter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(opa), .data_operandB(opb), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {exception, result} from plain signed arithmetic
  function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p != longint'($signed(p[31:0]))), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; opa = a; opb = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; opa = $urandom; opb = $urandom;
  endtask

  task automatic expect_rdy(input string tag, input int lat, input logic [31:0] er, input logic ee);
    int n = 0;
    int bc = 0;
    bit seen = 0;
    while (!seen && n < lat + 8) begin
      @(negedge clock);
      n++;
      if (data_resultRDY) seen = 1;
      else if (busy) bc++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " busy cycles"}, bc, lat - 1);
    check({tag, " result"}, data_result, er);
    check({tag, " exception"}, {31'd0, data_exception}, {31'd0, ee});
    check({tag, " busy at rdy"}, {31'd0, busy}, 32'd0);
    @(negedge clock);
    check({tag, " single pulse"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int rc;
    int n;
    bit is_mul;
    logic [31:0] a, b;
    logic [32:0] r;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'd0, data_exception}, 32'd0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    issue(1, 0, 32'd7, 32'hFFFF_FFFD);
    expect_rdy("mul 7*-3", MLAT, 32'hFFFF_FFEB, 1'b0);
    issue(1, 0, 32'h0001_0000, 32'h0001_0000);
    expect_rdy("mul 2^16*2^16", MLAT, 32'h0000_0000, 1'b1);
    issue(1, 0, 32'h4000_0000, 32'd2);
    expect_rdy("mul 2^30*2", MLAT, 32'h8000_0000, 1'b1);
    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_rdy("mul min*-1", MLAT, 32'h8000_0000, 1'b1);

    issue(0, 1, 32'hFFFF_FFEF, 32'd5);
    expect_rdy("div -17/5", DLAT, 32'hFFFF_FFFD, 1'b0);
    issue(0, 1, 32'd100, 32'd0);
    expect_rdy("div 100/0", DLAT, 32'd0, 1'b1);
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_rdy("div min/-1", DLAT, 32'h8000_0000, 1'b1);

    // Divide aborted by a multiply ten cycles later
    issue(0, 1, 32'd100, 32'd7);
    rc = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rc++;
    end
    check("abort no early rdy", rc, 0);
    issue(1, 0, 32'd6, 32'd6);
    expect_rdy("abort then mul 6*6", MLAT, 32'd36, 1'b0);

    issue(1, 1, 32'd12, 32'd4);
    expect_rdy("mul+div 12,4", MLAT, 32'd48, 1'b0);
    rc = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rc++;
    end
    check("mul+div no second rdy", rc, 0);

    // Reset in the middle of a multiply
    issue(1, 0, 32'd1234, 32'd5678);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midreset result", data_result, 32'd0);
    check("midreset exception", {31'd0, data_exception}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    rc = 0;
    repeat (45) begin
      @(negedge clock);
      if (data_resultRDY || busy) rc++;
    end
    check("midreset stays idle", rc, 0);
    issue(0, 1, 32'd9, 32'd3);
    expect_rdy("div 9/3 after reset", DLAT, 32'd3, 1'b0);

    // New start issued during the DONE cycle
    issue(1, 0, 32'd3, 32'd5);
    n = 0;
    while (!data_resultRDY && n < MLAT + 8) begin
      @(negedge clock);
      n++;
    end
    check("done-start first latency", n, MLAT);
    check("done-start first result", data_result, 32'd15);
    ctrl_DIV = 1'b1; opa = 32'd20; opb = 32'hFFFF_FFFC;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0; opa = $urandom; opb = $urandom;
    expect_rdy("done-start div 20/-4", DLAT, 32'hFFFF_FFFB, 1'b0);

    for (int i = 0; i < 24; i++) begin
      is_mul = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin
          a = int'($urandom_range(0, 65535)) - 32768;
          b = int'($urandom_range(0, 65535)) - 32768;
        end
        2: begin a = $urandom; b = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'hFFFF_FFFF; end
        default: begin a = 32'h8000_0000; b = int'($urandom_range(0, 6)) - 3; end
      endcase
      r = model(is_mul, a, b);
      issue(is_mul, !is_mul, a, b);
      expect_rdy(is_mul ? "rand mul" : "rand div", is_mul ? MLAT : DLAT, r[31:0], r[32]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Iterative signed 32-bit multiply/divide unit beside the ALU logic units (and/or/add/shift).
- Its result feeds the same execute-stage result mux as the bitwise units.
- Multicycle: a one-cycle start pulse latches the operands, the unit iterates, then pulses ready with the result and an exception flag.
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits; two's complement; must be even.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- ctrl_MULT  input  1  one-cycle start pulse for a multiply.
- ctrl_DIV  input  1  one-cycle start pulse for a divide.
- data_operandA  input  WIDTH  multiplicand / dividend; sampled only on the start cycle.
- data_operandB  input  WIDTH  multiplier / divisor; sampled only on the start cycle.
- data_result  output  WIDTH  product low WIDTH bits, or quotient.
- data_exception  output  1  overflow or divide-by-zero flag; valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle pulse; result and exception valid.
- busy  output  1  high while iterating.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, state=IDLE, counter=0.
- States:
  - IDLE: ctrl_MULT → MUL; ctrl_DIV → DIV; otherwise stay.
  - MUL: one radix-2 shift-add step per cycle; after WIDTH steps → DONE.
  - DIV: one restoring step per cycle on magnitudes; after WIDTH steps → DONE.
  - DONE: data_resultRDY=1 for exactly one cycle, then → IDLE.
- Latency: start asserted in cycle c → data_resultRDY high in cycle c+WIDTH+1 (33 for WIDTH=32). Identical for all operand values, including divide-by-zero.
- busy=1 in all MUL/DIV cycles. busy=0 in IDLE and DONE.
- data_result and data_exception are registered. They update on entry to DONE and hold until the next DONE or reset.
- Multiply:
  - Operands are signed; the internal product is 2*WIDTH bits.
  - data_result = low WIDTH bits.
  - data_exception=1 when the upper WIDTH+1 bits of the product are not all equal, i.e. the true product does not fit signed WIDTH.
- Divide:
  - Quotient truncates toward zero; the remainder is discarded.
  - Quotient sign = signA XOR signB.
  - Divisor 0: data_result=0, data_exception=1.
  - Dividend -2^(WIDTH-1) with divisor -1: data_result=0x80000000, data_exception=1.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins; divide is ignored.
- Start while busy (MUL or DIV): the current operation is aborted without a RDY pulse. The new operands are latched and the count restarts at 0. Latency is measured from the new pulse.
- Start in the DONE cycle: RDY still pulses this cycle; the new operation begins next cycle as if started from IDLE.
- Reset mid-operation: immediate return to IDLE; no RDY pulse; outputs cleared.
- Operand inputs may change freely after the start cycle without effect.

Optional Feature:
- Macro: MULTDIV_BOOTH_EN.
- Defined: multiply uses radix-4 modified Booth recoding, two bits per step, WIDTH/2 steps. Multiply latency becomes c+WIDTH/2+1 (17 for WIDTH=32). Divide is unchanged.
- Not defined: radix-2 shift-add multiply with WIDTH steps.
- Results and exception semantics are identical in both builds.

Test Plan:
- Reset, then ctrl_MULT with A=7, B=-3 → RDY in cycle c+33 (c+17 Booth), result=0xFFFFFFEB, exception=0, busy high 32 cycles.
- ctrl_MULT with A=0x00010000, B=0x00010000 → result=0x00000000, exception=1; A=0x40000000, B=2 → exception=1.
- ctrl_DIV with A=-17, B=5 → result=0xFFFFFFFD (-3), exception=0; A=100, B=0 → result=0, exception=1 at c+33; A=0x80000000, B=-1 → result=0x80000000, exception=1.
- ctrl_DIV at c, then ctrl_MULT at c+10 with A=6, B=6 → no RDY at c+33; RDY at c+43 with result=36.
- ctrl_MULT and ctrl_DIV together with A=12, B=4 → result=48 (multiply), a single RDY pulse.
- ctrl_MULT, then reset at c+5 for one cycle → outputs 0, busy=0, no RDY ever; the next ctrl_DIV with A=9, B=3 → result=3 at its normal latency.
